// File: rtl/avalon_timer_multi.sv
// avalon_timer_multi: NUM_CH independent Avalon-MM interval timers sharing one slave port
// and one combined interrupt line. Register map per channel (address[3:2] = channel):
//   0 STATUS {RUN,TO}, write clears TO | 1 CONTROL [0]ITO [1]CONT [2]START [3]STOP
//   2 PERIOD | 3 SNAP (write captures the live count)
// Optional build macro TIMER_PRESCALE_EN adds a per-channel 8-bit prescaler held in
// CONTROL[15:8]; without it the counters tick every clock and CONTROL[15:8] reads 0.
module avalon_timer_multi #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 32,
  parameter logic [31:0] PERIOD_INIT = 32'd9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [3:0]  address,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_INIT = PERIOD_INIT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                    wr_s;
  logic [1:0]              ch_s;
  logic [1:0]              reg_s;
  logic [NUM_CH-1:0]       irq_ch_s;
  logic [NUM_CH-1:0][31:0] rd_ch_s;
  logic [31:0]             readdata_d;
  logic                    unused_s;

  assign wr_s  = chipselect & ~write_n;
  assign ch_s  = address[3:2];
  assign reg_s = address[1:0];

  // Write-data bits that no register stores in every build still feed this sink.
  assign unused_s = ^writedata;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] count_q, count_d, period_q, period_d, snap_q, snap_d;
    logic             run_q, run_d, to_q, to_d, ito_q, ito_d, cont_q, cont_d;
    logic             hold0_q, hold0_d;
    logic             sel_s, wr_status_s, wr_ctrl_s, wr_period_s, wr_snap_s;
    logic             start_s, stop_s, fresh_s, tick_s, done_s, to_evt_s;
    logic [31:0]      period_ext_s, snap_ext_s, ctrl_rd_s, rd_s;

    assign sel_s       = wr_s & (ch_s == 2'(c));
    assign wr_status_s = sel_s & (reg_s == 2'd0);
    assign wr_ctrl_s   = sel_s & (reg_s == 2'd1);
    assign wr_period_s = sel_s & (reg_s == 2'd2);
    assign wr_snap_s   = sel_s & (reg_s == 2'd3);
    assign start_s     = wr_ctrl_s & writedata[2];
    assign stop_s      = wr_ctrl_s & writedata[3];
    // A START only restarts the prescaler / zero tracking when the channel was idle.
    assign fresh_s     = start_s & ~run_q;

`ifdef TIMER_PRESCALE_EN
    logic [7:0] psc_q, psc_d, pdiv_q, pdiv_d;

    // Prescaler: one counter tick every PRESCALE+1 clocks while running.
    always_comb begin
      tick_s = run_q & (psc_q == pdiv_q);
      if (wr_period_s | fresh_s) begin
        psc_d = 8'd0;
      end else if (tick_s) begin
        psc_d = 8'd0;
      end else if (run_q) begin
        psc_d = psc_q + 8'd1;
      end else begin
        psc_d = psc_q;
      end
      if (wr_ctrl_s) begin
        pdiv_d = writedata[15:8];
      end else begin
        pdiv_d = pdiv_q;
      end
    end

    // Prescaler state registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        psc_q  <= 8'd0;
        pdiv_q <= 8'd0;
      end else begin
        psc_q  <= psc_d;
        pdiv_q <= pdiv_d;
      end
    end

    assign ctrl_rd_s = {16'd0, pdiv_q, 6'd0, cont_q, ito_q};
`else
    assign tick_s    = run_q;
    assign ctrl_rd_s = {30'd0, cont_q, ito_q};
`endif

    // A one-shot run ends on the tick that reloads from zero, leaving count = PERIOD.
    assign done_s   = tick_s & (count_q == CNT_ZERO) & ~cont_q;
    // TO fires once per arrival at zero; hold0 suppresses repeats while zero is held (PERIOD=0).
    assign to_evt_s = tick_s & ~wr_period_s & (count_d == CNT_ZERO) & ~hold0_q;

    // Next-state for count, period, run flag, stored control bits and snapshot.
    always_comb begin
      if (wr_period_s) begin
        period_d = writedata[CNT_W-1:0];
        count_d  = writedata[CNT_W-1:0];
      end else if (tick_s) begin
        period_d = period_q;
        if (count_q == CNT_ZERO) begin
          count_d = period_q;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end else begin
        period_d = period_q;
        count_d  = count_q;
      end

      if (wr_period_s) begin
        run_d = 1'b0;
      end else if (start_s) begin
        run_d = 1'b1;
      end else if (stop_s | done_s) begin
        run_d = 1'b0;
      end else begin
        run_d = run_q;
      end

      // A new event wins over a simultaneous STATUS-write clear.
      if (to_evt_s) begin
        to_d = 1'b1;
      end else if (wr_status_s) begin
        to_d = 1'b0;
      end else begin
        to_d = to_q;
      end

      hold0_d = (count_d == CNT_ZERO) & ~wr_period_s & ~fresh_s & (to_evt_s | hold0_q);

      if (wr_ctrl_s) begin
        ito_d  = writedata[0];
        cont_d = writedata[1];
      end else begin
        ito_d  = ito_q;
        cont_d = cont_q;
      end

      if (wr_snap_s) begin
        snap_d = count_q;
      end else begin
        snap_d = snap_q;
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count_q  <= CNT_INIT;
        period_q <= CNT_INIT;
        snap_q   <= CNT_ZERO;
        run_q    <= 1'b0;
        to_q     <= 1'b0;
        ito_q    <= 1'b0;
        cont_q   <= 1'b0;
        hold0_q  <= 1'b0;
      end else begin
        count_q  <= count_d;
        period_q <= period_d;
        snap_q   <= snap_d;
        run_q    <= run_d;
        to_q     <= to_d;
        ito_q    <= ito_d;
        cont_q   <= cont_d;
        hold0_q  <= hold0_d;
      end
    end

    // Read word of this channel for the addressed register, upper bits zero.
    always_comb begin
      period_ext_s                = 32'd0;
      period_ext_s[CNT_W-1:0]     = period_q;
      snap_ext_s                  = 32'd0;
      snap_ext_s[CNT_W-1:0]       = snap_q;
      case (reg_s)
        2'd0:    rd_s = {30'd0, run_q, to_q};
        2'd1:    rd_s = ctrl_rd_s;
        2'd2:    rd_s = period_ext_s;
        2'd3:    rd_s = snap_ext_s;
        default: rd_s = 32'd0;
      endcase
    end

    assign rd_ch_s[c]  = rd_s;
    assign irq_ch_s[c] = to_q & ito_q;
  end

  // Select the addressed channel; channels beyond NUM_CH read as zero.
  always_comb begin
    if (int'(ch_s) < NUM_CH) begin
      readdata_d = rd_ch_s[ch_s];
    end else begin
      readdata_d = 32'd0;
    end
  end

  // Registered read data, refreshed every clock from the address mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= 32'd0;
    end else begin
      readdata <= readdata_d;
    end
  end

  assign irq = |irq_ch_s;

endmodule
